ring_scan_display: RTL and testbench
====================================

RING_SCAN_DISPLAY -- requirements
Module: ring_scan_display

Interface
- REQ-001: Parameter DIV, default 2, clock cycles per digit slot; legal range 1..256.
- REQ-002: Parameter LZB, default 1, leading-zero blanking enable (1 = on).
- REQ-003: clk  input  1  single rising-edge clock for all state.
- REQ-004: reset  input  1  asynchronous, active-low reset.
- REQ-005: load  input  1  one-cycle request to capture data.
- REQ-006: data  input  16  four BCD nibbles; digit3 = [15:12], digit0 = [3:0].
- REQ-007: an  output  4  one-hot digit select, active-high, ring order an[0]->an[1]->an[2]->an[3]->an[0].
- REQ-008: seg  output  7  segments {g,f,e,d,c,b,a}, active-high, for the digit selected by an.
- REQ-009: frame  output  1  one-cycle pulse marking the start of each new frame.
- REQ-010: load_ack  output  1  one-cycle pulse when pending data enters the display register.

Function
- REQ-011: The prescaler counts 0..DIV-1; "tick" is the cycle where the count is DIV-1; on tick the count returns to 0.
- REQ-012: On each tick edge, an rotates left by one position; a frame is therefore exactly 4*DIV cycles.
- REQ-013: an SHALL always be one-hot; any non-one-hot value SHALL be forced to 0001 on the next edge.
- REQ-014: Boundary = tick while an==1000; the boundary edge moves an to 0001.
- REQ-015: frame SHALL be high for exactly the first cycle of an==0001 following each boundary; never high after reset release alone.
- REQ-016: A load edge copies data into the shadow register and sets pending; a later load before transfer overwrites the shadow (last wins).
- REQ-017: On a boundary edge with pending already set, the shadow moves to the display register, pending clears, and load_ack is high the following cycle (coincident with frame).
- REQ-018: A load coincident with a boundary edge: the old shadow (if pending) transfers; the new data becomes the shadow and pending remains set for the next boundary.
- REQ-019: The display register SHALL change only on boundary edges; an, seg and frame remain glitch-free between boundaries.
- REQ-020: seg decode: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111; nibbles 10..15 give 1000000 ("-").
- REQ-021: With LZB=1, digit k (k=3..1) shows 0000000 when it and every higher digit equal 0; digit0 is never blanked; a nibble of 10..15 counts as non-zero.
- REQ-022: seg is a function of registered state only (display register, an); no combinational path from load or data.
- REQ-023: With DIV=1, an rotates every cycle and all other rules remain unchanged.

Reset
- REQ-024: While reset is low: prescaler=0, an=0001, display=0x0000, shadow=0x0000, pending=0, frame=0, load_ack=0; seg=0111111.
- REQ-025: Assertion takes effect immediately, without waiting for a clock edge; a pending load is discarded.
- REQ-026: After release, the first rotation occurs on the DIV-th rising edge.

Verification (DIV=2, LZB=1)
- REQ-027: Release reset, no load -> an sequence 0001,0001,0010,0010,0100,0100,1000,1000,0001...; seg is 0111111 only on digit0 and 0000000 elsewhere; first frame pulse at cycle 8.
- REQ-028: load with data=0x1234 mid-frame -> no change until the boundary; then load_ack and frame are high together; seg per digit0..3 = 1100110, 1001111, 1011011, 0000110.
- REQ-029: Two loads, 0x0007 then 0x00A0, within one frame -> only 0x00A0 is displayed; digit1 shows 1000000; digit0 shows 0111111; digits 3..2 are blank; exactly one load_ack pulse.
- REQ-030: load of 0x5555 exactly on a boundary edge, with 0x9999 pending -> 0x9999 is shown this frame; 0x5555 is shown next frame; two load_ack pulses, one frame apart.
- REQ-031: Reset asserted mid-frame with pending data -> an=0001 and seg=0111111 immediately; no load_ack pulse after release.
- REQ-032: Force a non-one-hot an (for example 0011) -> an=0001 on the next edge, and normal rotation then resumes.

Source files
------------

// File: rtl/ring_scan_display.sv
// Four-digit multiplexed 7-segment scanner with a ring-rotating digit select.
// New data is staged in a shadow register and shown only from a frame boundary on.
module ring_scan_display #(
    parameter int DIV = 2,
    parameter int LZB = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] data,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        frame,
    output logic        load_ack
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    an_q, an_d;
    logic [15:0]   disp_q, disp_d;
    logic [15:0]   shadow_q, shadow_d;
    logic          pending_q, pending_d;
    logic          frame_q, frame_d;
    logic          ack_q, ack_d;
    logic [6:0]    seg_q, seg_d;

    logic          tick;
    logic          onehot;
    logic          boundary;
    logic [3:0]    nib_sel;
    logic          blank;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'd0:    s = 7'b0111111;
            4'd1:    s = 7'b0000110;
            4'd2:    s = 7'b1011011;
            4'd3:    s = 7'b1001111;
            4'd4:    s = 7'b1100110;
            4'd5:    s = 7'b1101101;
            4'd6:    s = 7'b1111101;
            4'd7:    s = 7'b0000111;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1101111;
            default: s = 7'b1000000;
        endcase
        return s;
    endfunction

    always_comb begin
        tick   = (cnt_q == CNT_MAX);
        onehot = (an_q == 4'b0001) || (an_q == 4'b0010) ||
                 (an_q == 4'b0100) || (an_q == 4'b1000);
        boundary = tick && (an_q == 4'b1000);

        cnt_d = tick ? '0 : cnt_q + CW'(1);

        an_d = an_q;
        if (!onehot) begin
            an_d = 4'b0001;
        end else if (tick) begin
            an_d = {an_q[2:0], an_q[3]};
        end

        frame_d = boundary;
    end

    // Transfer uses the old shadow, so a load on the boundary edge waits a frame.
    always_comb begin
        disp_d    = disp_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        ack_d     = 1'b0;
        if (boundary && pending_q) begin
            disp_d    = shadow_q;
            pending_d = 1'b0;
            ack_d     = 1'b1;
        end
        if (load) begin
            shadow_d  = data;
            pending_d = 1'b1;
        end
    end

    // Segments are decoded from next state and registered, so they never glitch.
    always_comb begin
        nib_sel = disp_d[3:0];
        blank   = 1'b0;
        case (1'b1)
            an_d[0]: nib_sel = disp_d[3:0];
            an_d[1]: begin
                nib_sel = disp_d[7:4];
                blank   = (disp_d[15:4] == 12'h000);
            end
            an_d[2]: begin
                nib_sel = disp_d[11:8];
                blank   = (disp_d[15:8] == 8'h00);
            end
            an_d[3]: begin
                nib_sel = disp_d[15:12];
                blank   = (disp_d[15:12] == 4'h0);
            end
            default: nib_sel = disp_d[3:0];
        endcase
        seg_d = (blank && (LZB != 0)) ? 7'b0000000 : seg7(nib_sel);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q     <= '0;
            an_q      <= 4'b0001;
            disp_q    <= 16'h0000;
            shadow_q  <= 16'h0000;
            pending_q <= 1'b0;
            frame_q   <= 1'b0;
            ack_q     <= 1'b0;
            seg_q     <= 7'b0111111;
        end else begin
            cnt_q     <= cnt_d;
            an_q      <= an_d;
            disp_q    <= disp_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            frame_q   <= frame_d;
            ack_q     <= ack_d;
            seg_q     <= seg_d;
        end
    end

    assign an       = an_q;
    assign seg      = seg_q;
    assign frame    = frame_q;
    assign load_ack = ack_q;

endmodule

// File: tb/tb_ring_scan_display.sv
// Scoreboard bench for ring_scan_display (DIV=2, LZB=1).
// Stimulus queues expected per-cycle outputs; a monitor pops and compares.
module tb_ring_scan_display;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        load = 1'b0;
    logic [15:0] data = 16'h0000;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        frame;
    logic        load_ack;

    ring_scan_display #(.DIV(2), .LZB(1)) dut (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .data     (data),
        .an       (an),
        .seg      (seg),
        .frame    (frame),
        .load_ack (load_ack)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] S0   = 7'b0111111;
    localparam logic [6:0] S1   = 7'b0000110;
    localparam logic [6:0] S2   = 7'b1011011;
    localparam logic [6:0] S3   = 7'b1001111;
    localparam logic [6:0] S4   = 7'b1100110;
    localparam logic [6:0] S5   = 7'b1101101;
    localparam logic [6:0] S9   = 7'b1101111;
    localparam logic [6:0] DASH = 7'b1000000;
    localparam logic [6:0] OFF  = 7'b0000000;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       fr;
        logic       ack;
        int         k;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    int         n_chk = 0;
    int         n_fail = 0;
    int         k = 0;
    logic [6:0] cur_seg[4];
    logic [3:0] one = 4'b0001;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitor: one expected record per cycle, sampled after the rising edge.
    always @(posedge clk) begin
        #2;
        if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            chk($sformatf("an k=%0d", mon_e.k), 32'(an), 32'(mon_e.an));
            chk($sformatf("seg k=%0d", mon_e.k), 32'(seg), 32'(mon_e.seg));
            chk($sformatf("frame k=%0d", mon_e.k), 32'(frame), 32'(mon_e.fr));
            chk($sformatf("load_ack k=%0d", mon_e.k), 32'(load_ack),
                32'(mon_e.ack));
        end
    end

    task automatic set_seg(input logic [6:0] d0, input logic [6:0] d1,
                           input logic [6:0] d2, input logic [6:0] d3);
        cur_seg[0] = d0;
        cur_seg[1] = d1;
        cur_seg[2] = d2;
        cur_seg[3] = d3;
    endtask

    // Called at a falling edge: drive inputs for the next rising edge.
    task automatic step(input logic ld, input logic [15:0] d, input logic ack);
        exp_t e;
        int   slot;
        load  = ld;
        data  = d;
        k++;
        slot  = (k / 2) % 4;
        e.k   = k;
        e.an  = one << slot;
        e.seg = cur_seg[slot];
        e.fr  = (k % 8 == 0);
        e.ack = ack;
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic pre_bnd();
        while (k % 8 != 7) step(1'b0, 16'h0000, 1'b0);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 10) begin
            @(posedge clk);
            #3;
            t++;
        end
        chk("scoreboard drained", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not reach its end");
        $fatal(1, "timeout");
    end

    initial begin
        set_seg(S0, OFF, OFF, OFF);
        repeat (2) @(negedge clk);
        chk("reset an", 32'(an), 32'h1);
        chk("reset seg", 32'(seg), 32'(S0));
        chk("reset frame", 32'(frame), 32'h0);
        chk("reset load_ack", 32'(load_ack), 32'h0);
        reset = 1'b1;
        k = 0;

        // Idle frames: blank display, frame at 8 and 16.
        repeat (16) step(1'b0, 16'h0000, 1'b0);

        // Mid-frame load of 0x1234.
        repeat (3) step(1'b0, 16'h0000, 1'b0);
        step(1'b1, 16'h1234, 1'b0);
        pre_bnd();
        set_seg(S4, S3, S2, S1);
        step(1'b0, 16'h0000, 1'b1);
        repeat (8) step(1'b0, 16'h0000, 1'b0);

        // Last load wins within a frame.
        step(1'b1, 16'h0007, 1'b0);
        step(1'b0, 16'h0000, 1'b0);
        step(1'b1, 16'h00A0, 1'b0);
        pre_bnd();
        set_seg(S0, DASH, OFF, OFF);
        step(1'b0, 16'h0000, 1'b1);
        repeat (8) step(1'b0, 16'h0000, 1'b0);

        // Load on the boundary edge while 0x9999 is pending.
        step(1'b1, 16'h9999, 1'b0);
        pre_bnd();
        set_seg(S9, S9, S9, S9);
        step(1'b1, 16'h5555, 1'b1);
        pre_bnd();
        set_seg(S5, S5, S5, S5);
        step(1'b0, 16'h0000, 1'b1);
        repeat (8) step(1'b0, 16'h0000, 1'b0);

        // Asynchronous reset with 0x4321 pending.
        step(1'b1, 16'h4321, 1'b0);
        repeat (2) step(1'b0, 16'h0000, 1'b0);
        drain();
        #1 reset = 1'b0;
        #1;
        chk("async reset an", 32'(an), 32'h1);
        chk("async reset seg", 32'(seg), 32'(S0));
        chk("async reset frame", 32'(frame), 32'h0);
        chk("async reset load_ack", 32'(load_ack), 32'h0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        k = 0;
        set_seg(S0, OFF, OFF, OFF);
        repeat (18) step(1'b0, 16'h0000, 1'b0);
        drain();
        @(negedge clk);

        // After edge 19 the ring is at 0010 with prescaler at 1.
        force dut.an_q = 4'b0011;
        #1;
        chk("forced an", 32'(an), 32'h3);
        #1 release dut.an_q;
        @(posedge clk);
        #1;
        chk("recover an", 32'(an), 32'h1);
        chk("recover frame", 32'(frame), 32'h0);
        @(posedge clk);
        #1;
        chk("resume an 1", 32'(an), 32'h1);
        @(posedge clk);
        #1;
        chk("resume an 2", 32'(an), 32'h2);
        chk("resume seg 2", 32'(seg), 32'(OFF));
        @(posedge clk);
        #1;
        chk("resume an 3", 32'(an), 32'h2);
        @(posedge clk);
        #1;
        chk("resume an 4", 32'(an), 32'h4);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
